// File: rtl/alu_issue_wb_if.sv
// Instruction handshake, alu drive/return and writeback bus of the issue/writeback stage.
// The stage uses the slave modport; the instruction source and alu use master.
interface alu_issue_wb_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [4:0]  alu_op;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_result;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_op, alu_in1, alu_in2, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_op, alu_in1, alu_in2, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/alu_issue_wb.sv
// Operand fetch, issue and writeback around an external combinational alu.
// One instruction per cycle; the only hazard (E-stage result) is resolved by forwarding.
module alu_issue_wb #(
  parameter int unsigned NREGS = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [5:0]        ld_addr,
  input  logic [15:0]       ld_data,
  alu_issue_wb_if.slave     bus,
  input  logic [5:0]        dbg_addr,
  output logic [15:0]       dbg_data,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      stateQ, stateD;
  logic [15:0] regFile [NREGS];
  logic        eValid;
  logic [4:0]  aluOpQ;
  logic [15:0] in1Q, in2Q;
  logic [5:0]  wrAddrQ;

  logic [3:0]  opcode;
  logic [5:0]  dest, src;
  logic        accept, isAlu, isHalt, isIllegal, ldEn;
  logic [15:0] fwdDest, fwdSrc;

  always_comb begin
    opcode    = bus.instr[15:12];
    dest      = bus.instr[11:6];
    src       = bus.instr[5:0];
    accept    = bus.instr_valid && (stateQ == RUN);
    isAlu     = (opcode <= 4'd11);
    isHalt    = (opcode == 4'hF);
    isIllegal = !isAlu && !isHalt;
    ldEn      = ld_valid && ((stateQ == IDLE) || (stateQ == HALTED));
  end

  // The E-stage result is not yet in the register file; bypass it to the issuing operands.
  always_comb begin
    fwdDest = (eValid && (wrAddrQ == dest)) ? bus.alu_result : regFile[dest];
    fwdSrc  = (eValid && (wrAddrQ == src))  ? bus.alu_result : regFile[src];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (start) stateD = RUN;
      RUN:     if (accept && !isAlu) stateD = HALTED;
      HALTED:  if (start) stateD = RUN;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regFile <= '{default: '0};
      eValid  <= 1'b0;
      aluOpQ  <= '0;
      in1Q    <= '0;
      in2Q    <= '0;
      wrAddrQ <= '0;
      error   <= 1'b0;
      retired <= '0;
    end else begin
      // Preload only happens outside RUN, where eValid is always 0, so the writes never collide.
      if (ldEn) regFile[ld_addr] <= ld_data;
      if (eValid) begin
        regFile[wrAddrQ] <= bus.alu_result;
        retired          <= retired + CNT_W'(1);
      end
      eValid <= accept && isAlu;
      if (accept && isAlu) begin
        aluOpQ  <= {1'b0, opcode};
        in1Q    <= fwdDest;
        in2Q    <= fwdSrc;
        wrAddrQ <= dest;
      end
      if (accept && isIllegal)              error <= 1'b1;
      else if (stateQ == HALTED && start)   error <= 1'b0;
    end
  end

  always_comb begin
    bus.instr_ready = (stateQ == RUN);
    bus.alu_op      = aluOpQ;
    bus.alu_in1     = in1Q;
    bus.alu_in2     = in2Q;
    bus.wr_en       = eValid;
    bus.wr_addr     = wrAddrQ;
    bus.wr_data     = bus.alu_result;
    halted          = (stateQ == HALTED);
    dbg_data        = regFile[dbg_addr];
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb: directed scenarios plus a randomized stream
// checked against an architectural (one-instruction-at-a-time) register model.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;
  logic [5:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        halted;
  logic        error;
  logic [15:0] retired;

  alu_issue_wb_if ifc ();

  alu_issue_wb #(.NREGS(64), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .bus      (ifc),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .halted   (halted),
    .error    (error),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Stand-in alu: an arbitrary but fixed function of op/in1/in2.
  function automatic logic [15:0] aluF(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op[3:0])
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return a ^ b;
      4'd4:    return a & b;
      4'd5:    return a << b[3:0];
      4'd6:    return a >> b[3:0];
      4'd7:    return ~a;
      4'd8:    return a + 16'd1;
      4'd9:    return b;
      4'd10:   return 16'(a * b);
      4'd11:   return {a[7:0], b[7:0]};
      default: return 16'hDEAD;
    endcase
  endfunction

  always_comb ifc.alu_result = aluF(ifc.alu_op, ifc.alu_in1, ifc.alu_in2);

  int unsigned nPass = 0;
  int unsigned nTotal = 0;
  logic [15:0] model [64];
  int unsigned modelRetired;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    ifc.instr_valid = 1'b0; ifc.instr = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = '0;
    modelRetired = 0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
    model[a] = d;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one instruction for one edge; the model executes it in program order.
  task automatic issue(input logic [15:0] w, output logic [15:0] expData);
    logic [3:0] op;
    logic [5:0] d, s;
    op = w[15:12]; d = w[11:6]; s = w[5:0];
    ifc.instr_valid = 1'b1; ifc.instr = w;
    tick();
    ifc.instr_valid = 1'b0;
    expData = '0;
    if (op <= 4'd11) begin
      expData = aluF({1'b0, op}, model[d], model[s]);
      model[d] = expData;
      modelRetired++;
    end
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    #1;
    nTotal++; if ({ifc.wr_en, ifc.instr_ready, halted, error} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {ifc.wr_en, ifc.instr_ready, halted, error}); else nPass++;
    nTotal++; if (retired !== 16'd0) $display("FAIL reset_retired got %0d exp 0", retired); else nPass++;
    nTotal++; if ({ifc.alu_op, ifc.alu_in1, ifc.alu_in2, ifc.wr_addr} !== '0) $display("FAIL reset_alu_bus got %h/%h/%h/%h exp 0", ifc.alu_op, ifc.alu_in1, ifc.alu_in2, ifc.wr_addr); else nPass++;
    doReset();
    nTotal++; if (ifc.instr_ready !== 1'b0) $display("FAIL idle_ready got %b exp 0", ifc.instr_ready); else nPass++;
  endtask

  task automatic test_add();
    logic [15:0] e;
    doReset();
    preload(6'd1, 16'h0003);
    preload(6'd2, 16'h0005);
    pulseStart();
    nTotal++; if (ifc.instr_ready !== 1'b1) $display("FAIL run_ready got %b exp 1", ifc.instr_ready); else nPass++;
    issue(16'h0042, e);
    nTotal++; if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 6'd1) $display("FAIL add_wr got en=%b addr=%0d exp en=1 addr=1", ifc.wr_en, ifc.wr_addr); else nPass++;
    nTotal++; if (ifc.wr_data !== 16'h0008) $display("FAIL add_data got %h exp 0008", ifc.wr_data); else nPass++;
    nTotal++; if (ifc.alu_in1 !== 16'h0003 || ifc.alu_in2 !== 16'h0005 || ifc.alu_op !== 5'd0) $display("FAIL add_operands got %h %h op %h exp 0003 0005 op 00", ifc.alu_in1, ifc.alu_in2, ifc.alu_op); else nPass++;
    dbg_addr = 6'd1;
    tick();
    nTotal++; if (dbg_data !== 16'h0008 || retired !== 16'd1) $display("FAIL add_commit got r1=%h retired=%0d exp r1=0008 retired=1", dbg_data, retired); else nPass++;
    nTotal++; if (ifc.wr_en !== 1'b0) $display("FAIL add_wr_en_drop got %b exp 0", ifc.wr_en); else nPass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    doReset();
    preload(6'd1, 16'h0003);
    preload(6'd2, 16'h0005);
    pulseStart();
    issue(16'h0042, e);
    nTotal++; if (ifc.instr_ready !== 1'b1 || ifc.wr_data !== e) $display("FAIL b2b_first got ready=%b data=%h exp ready=1 data=%h", ifc.instr_ready, ifc.wr_data, e); else nPass++;
    issue(16'h0042, e);
    nTotal++; if (ifc.alu_in1 !== 16'h0008) $display("FAIL b2b_forward got %h exp 0008", ifc.alu_in1); else nPass++;
    nTotal++; if (ifc.wr_data !== 16'h000D || ifc.instr_ready !== 1'b1) $display("FAIL b2b_second got data=%h ready=%b exp data=000d ready=1", ifc.wr_data, ifc.instr_ready); else nPass++;
    dbg_addr = 6'd1;
    tick();
    nTotal++; if (dbg_data !== 16'h000D || retired !== 16'd2) $display("FAIL b2b_commit got r1=%h retired=%0d exp r1=000d retired=2", dbg_data, retired); else nPass++;
  endtask

  task automatic test_and_halt();
    logic [15:0] e;
    doReset();
    preload(6'd3, 16'h00F0);
    preload(6'd4, 16'h0F0F);
    pulseStart();
    issue(16'h4104, e);
    nTotal++; if (ifc.alu_op !== 5'd4 || ifc.wr_addr !== 6'd4 || ifc.wr_data !== 16'h0F0F) $display("FAIL and_self got op=%h addr=%0d data=%h exp op=04 addr=4 data=0f0f", ifc.alu_op, ifc.wr_addr, ifc.wr_data); else nPass++;
    issue(16'h40C4, e);
    nTotal++; if (ifc.wr_addr !== 6'd3 || ifc.wr_data !== 16'h0000) $display("FAIL and_r3 got addr=%0d data=%h exp addr=3 data=0000", ifc.wr_addr, ifc.wr_data); else nPass++;
    issue(16'hF000, e);
    nTotal++; if ({halted, ifc.instr_ready, error, ifc.wr_en} !== 4'b1000) $display("FAIL halt_flags got %b exp 1000", {halted, ifc.instr_ready, error, ifc.wr_en}); else nPass++;
    dbg_addr = 6'd3;
    #1;
    nTotal++; if (dbg_data !== 16'h0000 || retired !== 16'd2) $display("FAIL halt_state got r3=%h retired=%0d exp r3=0000 retired=2", dbg_data, retired); else nPass++;
    ifc.instr_valid = 1'b1; ifc.instr = 16'h0042;
    tick();
    ifc.instr_valid = 1'b0;
    nTotal++; if (ifc.wr_en !== 1'b0 || halted !== 1'b1) $display("FAIL halt_blocks got wr_en=%b halted=%b exp wr_en=0 halted=1", ifc.wr_en, halted); else nPass++;
  endtask

  task automatic test_illegal();
    logic [15:0] e;
    doReset();
    preload(6'd1, 16'h0003);
    preload(6'd2, 16'h0005);
    pulseStart();
    issue(16'h0042, e);
    issue(16'hC000, e);
    nTotal++; if (retired !== 16'd1 || ifc.wr_en !== 1'b0) $display("FAIL illegal_retire got retired=%0d wr_en=%b exp retired=1 wr_en=0", retired, ifc.wr_en); else nPass++;
    nTotal++; if (error !== 1'b1 || halted !== 1'b1) $display("FAIL illegal_flags got error=%b halted=%b exp 1 1", error, halted); else nPass++;
    dbg_addr = 6'd1;
    #1;
    nTotal++; if (dbg_data !== 16'h0008) $display("FAIL illegal_wb got r1=%h exp 0008", dbg_data); else nPass++;
    pulseStart();
    nTotal++; if ({halted, error, ifc.instr_ready} !== 3'b001) $display("FAIL restart got halted/error/ready=%b exp 001", {halted, error, ifc.instr_ready}); else nPass++;
  endtask

  task automatic test_preload_gating();
    logic [15:0] e;
    // Continues in RUN from test_illegal.
    ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 16'hFFFF; dbg_addr = 6'd5;
    tick();
    ld_valid = 1'b0;
    nTotal++; if (dbg_data !== 16'h0000) $display("FAIL ld_in_run got r5=%h exp 0000", dbg_data); else nPass++;
    issue(16'hF000, e);
    preload(6'd5, 16'hFFFF);
    nTotal++; if (dbg_data !== 16'hFFFF || halted !== 1'b1) $display("FAIL ld_in_halted got r5=%h halted=%b exp ffff 1", dbg_data, halted); else nPass++;
  endtask

  task automatic test_random();
    logic [15:0] w, e;
    logic [3:0]  op;
    logic        offer;
    doReset();
    for (int i = 0; i < 64; i++) preload(6'(i), 16'($urandom));
    pulseStart();
    for (int c = 0; c < 400; c++) begin
      offer = ($urandom_range(3) != 0);
      op    = 4'($urandom_range(11));
      w     = {op, 12'($urandom_range(4095))};
      // Restrict operands to a few registers so forwarding is exercised often.
      if ($urandom_range(1) == 1) w[11:0] = {3'b000, 3'($urandom_range(3)), 3'b000, 3'($urandom_range(3))};
      ld_valid = ($urandom_range(7) == 0); ld_addr = 6'($urandom); ld_data = 16'($urandom);
      start = ($urandom_range(15) == 0);
      dbg_addr = 6'($urandom);
      if (offer) begin
        issue(w, e);
        nTotal++; if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== w[11:6] || ifc.wr_data !== e) $display("FAIL rand_wb c=%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h", c, ifc.wr_en, ifc.wr_addr, ifc.wr_data, w[11:6], e); else nPass++;
      end else begin
        tick();
        nTotal++; if (ifc.wr_en !== 1'b0 || dbg_data !== model[dbg_addr]) $display("FAIL rand_idle c=%0d got en=%b r%0d=%h exp en=0 %h", c, ifc.wr_en, dbg_addr, dbg_data, model[dbg_addr]); else nPass++;
      end
    end
    ld_valid = 1'b0; start = 1'b0;
    issue(16'hF000, e);
    nTotal++; if (halted !== 1'b1 || retired !== 16'(modelRetired)) $display("FAIL rand_retired got halted=%b retired=%0d exp 1 %0d", halted, retired, modelRetired); else nPass++;
    for (int i = 0; i < 64; i++) begin
      dbg_addr = 6'(i);
      #1;
      nTotal++; if (dbg_data !== model[i]) $display("FAIL rand_reg r%0d got %h exp %h", i, dbg_data, model[i]); else nPass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    doReset();
    preload(6'd1, 16'h0003);
    preload(6'd2, 16'h0005);
    preload(6'd7, 16'h1234);
    pulseStart();
    issue(16'h0042, e);
    nTotal++; if (ifc.wr_en !== 1'b1) $display("FAIL midrst_pending got %b exp 1", ifc.wr_en); else nPass++;
    rst_n = 1'b0;
    #1;
    nTotal++; if ({ifc.wr_en, ifc.instr_ready, halted, error} !== 4'b0 || retired !== 16'd0) $display("FAIL midrst_flags got %b retired=%0d exp 0000 0", {ifc.wr_en, ifc.instr_ready, halted, error}, retired); else nPass++;
    nTotal++; if ({ifc.alu_op, ifc.alu_in1, ifc.alu_in2, ifc.wr_addr} !== '0) $display("FAIL midrst_bus got %h/%h/%h/%h exp 0", ifc.alu_op, ifc.alu_in1, ifc.alu_in2, ifc.wr_addr); else nPass++;
    tick();
    rst_n = 1'b1;
    tick();
    nTotal++; if (retired !== 16'd0 || ifc.instr_ready !== 1'b0) $display("FAIL midrst_after got retired=%0d ready=%b exp 0 0", retired, ifc.instr_ready); else nPass++;
    for (int i = 0; i < 64; i++) begin
      dbg_addr = 6'(i);
      #1;
      nTotal++; if (dbg_data !== 16'h0000) $display("FAIL midrst_reg r%0d got %h exp 0000", i, dbg_data); else nPass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_and_halt();
    test_illegal();
    test_preload_gating();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Operand-fetch, issue and writeback stage sitting directly upstream and downstream of the combinational alu.
- Accepts 16-bit instructions in the format Opcode[15:12], Dest[11:6], Src[5:0].
- Reads reg[Dest] and reg[Src] from a 64x16 register file, drives the alu op/in1/in2 from registered issue state, and writes alu result back to reg[Dest] one cycle later.
- Register forwarding allows back-to-back dependent instructions without stalls; a small FSM handles start/halt/illegal opcodes.

Parameters:
NREGS, 64, register file depth (address width = 6, fixed by Dest/Src fields)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: IDLE/HALTED -> RUN
ld_valid  input  1  register preload strobe (honoured only in IDLE/HALTED)
ld_addr  input  6  preload register index
ld_data  input  16  preload value
instr_valid  input  1  instruction offered
instr  input  16  instruction word
instr_ready  output  1  stage can accept (1 only in RUN)
alu_op  output  5  to alu op ({1'b0, opcode})
alu_in1  output  16  to alu in1 (reg[Dest] value)
alu_in2  output  16  to alu in2 (reg[Src] value)
alu_result  input  16  from alu result (combinational on alu_op/in1/in2)
wr_en  output  1  writeback occurs at next edge (= e_valid)
wr_addr  output  6  writeback register
wr_data  output  16  writeback data (= alu_result)
dbg_addr  input  6  debug read index
dbg_data  output  16  reg[dbg_addr], combinational, pre-writeback value
halted  output  1  state == HALTED
error  output  1  sticky illegal-opcode flag
retired  output  CNT_W  count of written-back instructions, wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all 64 registers = 0; e_valid=0; alu_op/alu_in1/alu_in2 = 0; wr_addr = 0.
  - error=0; retired=0; instr_ready=0; halted=0.
- FSM states:
  - IDLE: start -> RUN; ld_valid writes reg[ld_addr]<=ld_data.
  - RUN: instr_ready=1; ld_valid ignored; start ignored.
  - HALTED: halted=1; ld_valid honoured; start -> RUN and clears error.
- Accept rule: accept at edge when instr_valid && instr_ready. The offering side holds instr stable until accepted.
- Opcode 0000-1011 (ALU op) at accept edge:
  - e_valid<=1; alu_op<={1'b0,opcode}; wr_addr<=Dest.
  - alu_in1<=fwd(Dest); alu_in2<=fwd(Src).
- Forwarding: fwd(r) = alu_result if (e_valid && wr_addr==r), else reg[r]. This is the only hazard path, so no stalls ever.
- Opcode 1111 (HALT) at accept edge: e_valid<=0; state<=HALTED. HALT is not counted in retired.
- Opcode 1100-1110 (illegal) at accept edge: error<=1; e_valid<=0; state<=HALTED.
- Writeback: at every edge with e_valid=1:
  - reg[wr_addr]<=alu_result;
  - retired<=retired+1 (mod 2^CNT_W);
  - e_valid<=0 unless a new ALU op is accepted at the same edge.
- Latency: an instruction accepted at edge N has its operands on alu_in* during cycle N..N+1 and writes back at edge N+1. Throughput is 1 instruction/cycle.
- Simultaneous writeback and HALT/illegal accept: the writeback completes and the E stage empties, so halted asserts with no pending write.
- Dest==Src: both operands take the same (possibly forwarded) value.
- alu_op/alu_in1/alu_in2/wr_addr hold their last values while e_valid=0. wr_en=0 masks them.
- start and a RUN-state event in the same cycle: the RUN event wins; start is ignored outside IDLE/HALTED.
- Reset mid-RUN: pending writeback is discarded; registers are cleared.

Test Plan:
- Preload r1=0x0003, r2=0x0005; start; instr 0x0042 (add r1,r2) -> next cycle wr_en=1, wr_addr=1, wr_data=0x0008; after edge dbg r1=0x0008, retired=1.
- Same preload, two back-to-back 0x0042 -> second issue has alu_in1=0x0008 via forwarding; r1 ends 0x000D; retired=2; instr_ready never drops.
- Preload r3=0x00F0, r4=0x0F0F; 0x4104 (and r4? no: and r4,r4) then 0x40C4 (and r3,r4) -> r3=0x0000; 0xF000 -> halted=1 next cycle, instr_ready=0, error=0.
- Illegal 0xC000 while previous add writes back -> add retires (retired increments), error=1, halted=1. Then start -> RUN, error=0.
- ld_valid in RUN with ld_addr=5, ld_data=0xFFFF -> r5 unchanged (0). Same preload in HALTED -> r5=0xFFFF.
- rst_n low mid-stream with e_valid=1 -> immediately IDLE, all outputs zero, no writeback; dbg reads 0 for all 64 registers.
